dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache with its controller FSM, between CPU load/store and data memory.
//  Hits served with no stall; misses stall CPU via BUSYWAIT while FSM sequences data memory (write-back, fetch, update).
//  Data memory is word-organised (4-byte blocks) with its own busywait handshake.
// PARAMETERS
//  INDEX_BITS  3  log2(#blocks); 8 blocks x 4 bytes. Tag = 6-INDEX_BITS bits.
// PORTS
//  CLK             in   1   clock, rising edge
//  RESET           in   1   asynchronous, active-low reset
//  READ            in   1   CPU load request (level, held until BUSYWAIT low)
//  WRITE           in   1   CPU store request (level, held until BUSYWAIT low)
//  ADDRESS         in   8   CPU byte address: {tag, index, offset[1:0]}
//  WRITEDATA       in   8   store data
//  READDATA        out  8   load data
//  BUSYWAIT        out  1   CPU stall
//  MEM_READ        out  1   memory block read request
//  MEM_WRITE       out  1   memory block write request
//  MEM_ADDRESS     out  6   memory block address {tag, index}
//  MEM_WRITEDATA   out  32  block write data, byte0 in [7:0]
//  MEM_READDATA    in   32  block read data, byte0 in [7:0]
//  MEM_BUSYWAIT    in   1   memory busy; request complete on first sampled-low cycle
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE; all valid/dirty bits 0; BUSYWAIT, MEM_READ, MEM_WRITE=0; READDATA, MEM_ADDRESS, MEM_WRITEDATA=0.
//  Reset mid-miss aborts memory transaction immediately; MEM_* requests drop without waiting for MEM_BUSYWAIT.
//  Hit = valid[index] & (tag[index]==ADDRESS tag); comb. READ & WRITE both high: WRITE wins.
//  BUSYWAIT comb. = (READ|WRITE) & ~(state==IDLE & hit); low when no request.
//  Read hit: READDATA = selected byte, same cycle; zero added latency.
//  Write hit: byte written, dirty[index]=1 at next rising edge; BUSYWAIT low same cycle.
//  FSM states: IDLE, WRITE_BACK, FETCH, UPDATE.
//   IDLE: on miss, dirty victim -> WRITE_BACK; clean or invalid victim -> FETCH.
//   WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim block; on MEM_BUSYWAIT=0 -> FETCH.
//   FETCH: MEM_READ=1, MEM_ADDRESS={req tag,index}; on MEM_BUSYWAIT=0 -> UPDATE.
//   UPDATE (1 cycle): block<=MEM_READDATA, tag<=req tag, valid=1, dirty=0; -> IDLE. No MEM_* request asserted.
//  After UPDATE, request re-evaluates as hit in IDLE. Stores apply then and set dirty.
//  Miss penalty, clean: 1 (IDLE) + N (FETCH) + 1 (UPDATE) cycles. N = memory busy cycles + 1. Dirty adds WRITE_BACK cycles.
//  MEM_READ and MEM_WRITE never both high. Request held stable across a miss; MEM_ADDRESS latched at IDLE exit.
//  CPU request dropped mid-miss: current memory transaction finishes, FSM returns to IDLE, no block update lost.
//  Offset selects byte: 0->[7:0], 1->[15:8], 2->[23:16], 3->[31:24].
//  Index wrap: addresses 0x00 and 0x20 share index 0 and evict each other.
// TESTING (memory model: MEM_BUSYWAIT high 5 cycles after request)
//  1 Release reset, READ 0x04 -> FETCH with MEM_ADDRESS=0x01, 5 busy cycles, UPDATE; READDATA=mem byte 0x04; BUSYWAIT low after 8 cycles.
//  2 READ 0x05 right after test 1 -> hit: BUSYWAIT never high, READDATA=mem byte 0x05 same cycle.
//  3 WRITE 0x06=0xAB (hit) then READ 0x06 -> 0xAB; dirty[1]=1; no MEM_WRITE seen.
//  4 READ 0x24 (same index 1, dirty) -> WRITE_BACK MEM_ADDRESS=0x01, MEM_WRITEDATA byte2=0xAB; then FETCH MEM_ADDRESS=0x09.
//  5 WRITE 0x10=0x55 on invalid line -> fetch, then byte written; READ 0x10 -> 0x55; dirty[4]=1.
//  6 Assert RESET=0 during FETCH -> MEM_READ, BUSYWAIT to 0 immediately; after release, READ 0x04 misses again.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache sitting between a CPU
// load/store port and a word-organised data memory with its own busywait.
module dcache_controller #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic [1:0]  o_dbg_state
);
  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  // Memory handshake: a request is held until MEM_BUSYWAIT is sampled low,
  // which completes it on that rising edge.
  typedef enum logic [1:0] {S_IDLE, S_WRITE_BACK, S_FETCH, S_UPDATE} state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic [TAG_BITS-1:0]   r_req_tag;
  logic [INDEX_BITS-1:0] r_req_index;
  logic [31:0]           r_fill;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_offset;
  logic                  w_req;
  logic                  w_hit;
  logic [31:0]           w_line;
  logic [7:0]            w_byte;

  assign w_tag    = ADDRESS[7:2+INDEX_BITS];
  assign w_index  = ADDRESS[2+INDEX_BITS-1:2];
  assign w_offset = ADDRESS[1:0];
  assign w_req    = READ | WRITE;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line   = r_data[w_index];
  assign w_byte   = w_line[{w_offset, 3'b000} +: 8];

  // Stall is gated by reset so an aborted miss releases the CPU at once.
  assign BUSYWAIT    = RESET & w_req & ~((r_state == S_IDLE) & w_hit);
  assign READDATA    = w_hit ? w_byte : 8'h00;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_req_tag     <= '0;
      r_req_index   <= '0;
      r_fill        <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (WRITE) begin
                r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
                r_dirty[w_index] <= 1'b1;
              end
            end else begin
              // Latch the request so a dropped CPU request cannot corrupt the refill.
              r_req_tag   <= w_tag;
              r_req_index <= w_index;
              if (r_dirty[w_index]) begin
                r_state       <= S_WRITE_BACK;
                MEM_WRITE     <= 1'b1;
                MEM_ADDRESS   <= {r_tag[w_index], w_index};
                MEM_WRITEDATA <= r_data[w_index];
              end else begin
                r_state     <= S_FETCH;
                MEM_READ    <= 1'b1;
                MEM_ADDRESS <= {w_tag, w_index};
              end
            end
          end
        end
        S_WRITE_BACK: begin
          if (!MEM_BUSYWAIT) begin
            r_state     <= S_FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {r_req_tag, r_req_index};
          end
        end
        S_FETCH: begin
          if (!MEM_BUSYWAIT) begin
            r_state  <= S_UPDATE;
            MEM_READ <= 1'b0;
            r_fill   <= MEM_READDATA;
          end
        end
        S_UPDATE: begin
          r_data[r_req_index]  <= r_fill;
          r_tag[r_req_index]   <= r_req_tag;
          r_valid[r_req_index] <= 1'b1;
          r_dirty[r_req_index] <= 1'b0;
          r_state              <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a 5-busy-cycle block memory responder plus a
// flat byte-memory and cache-directory reference model.
module tb_dcache_controller;
  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [1:0]  dbg_state;

  int compared = 0;
  int mismatched = 0;

  dcache_controller #(.INDEX_BITS(3)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- memory responder ----------------
  logic [31:0] mem      [64];
  logic [31:0] seed_blk [64];
  logic        mem_ready = 1'b0;
  int unsigned mem_cnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt != 5);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_blk[i];
      mem_ready <= 1'b1;
    end
    if (MEM_READ | MEM_WRITE) begin
      if (mem_cnt == 5) begin
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        mem_cnt <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_byte [256];
  bit         m_valid  [8];
  bit         m_dirty  [8];
  logic [2:0] m_tag    [8];

  function automatic logic [31:0] ref_block(input logic [5:0] blk);
    logic [7:0] a;
    a = {blk, 2'b00};
    return {ref_byte[a + 8'd3], ref_byte[a + 8'd2], ref_byte[a + 8'd1], ref_byte[a]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input bit rd, input bit wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input string name);
    logic [2:0]  idx;
    logic [2:0]  tag;
    bit          hit, wb, saw_wb, saw_rd, both;
    int          exp_cycles, n;
    logic [5:0]  exp_wb_addr, got_wb_addr, got_rd_addr;
    logic [31:0] exp_wb_data, got_wb_data;
    idx         = addr[4:2];
    tag         = addr[7:5];
    hit         = m_valid[idx] && (m_tag[idx] == tag);
    wb          = !hit && m_valid[idx] && m_dirty[idx];
    exp_cycles  = hit ? 0 : (wb ? 14 : 8);
    exp_wb_addr = {m_tag[idx], idx};
    exp_wb_data = ref_block(exp_wb_addr);
    saw_wb = 0; saw_rd = 0; both = 0; n = 0;
    got_wb_addr = '0; got_wb_data = '0; got_rd_addr = '0;

    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    #1;
    while (BUSYWAIT && n < 100) begin
      if (MEM_READ && MEM_WRITE) both = 1;
      if (MEM_WRITE && !saw_wb) begin
        saw_wb = 1; got_wb_addr = MEM_ADDRESS; got_wb_data = MEM_WRITEDATA;
      end
      if (MEM_READ && !saw_rd) begin
        saw_rd = 1; got_rd_addr = MEM_ADDRESS;
      end
      @(negedge CLK); #1;
      n++;
    end

    compared++;
    if (n !== exp_cycles) begin
      mismatched++;
      $display("FAIL %s stall_cycles addr=%h got %0d expected %0d", name, addr, n, exp_cycles);
    end
    compared++;
    if (saw_wb !== wb) begin
      mismatched++;
      $display("FAIL %s writeback_seen addr=%h got %0d expected %0d", name, addr, saw_wb, wb);
    end
    if (wb) begin
      compared++;
      if (got_wb_addr !== exp_wb_addr) begin
        mismatched++;
        $display("FAIL %s wb_address got %h expected %h", name, got_wb_addr, exp_wb_addr);
      end
      compared++;
      if (got_wb_data !== exp_wb_data) begin
        mismatched++;
        $display("FAIL %s wb_data got %h expected %h", name, got_wb_data, exp_wb_data);
      end
    end
    compared++;
    if (saw_rd !== !hit) begin
      mismatched++;
      $display("FAIL %s fetch_seen addr=%h got %0d expected %0d", name, addr, saw_rd, !hit);
    end
    if (!hit) begin
      compared++;
      if (got_rd_addr !== {tag, idx}) begin
        mismatched++;
        $display("FAIL %s fetch_address got %h expected %h", name, got_rd_addr, {tag, idx});
      end
    end
    compared++;
    if (both !== 1'b0) begin
      mismatched++;
      $display("FAIL %s mem_read_and_write_together got 1 expected 0", name);
    end
    if (rd && !wr) begin
      compared++;
      if (READDATA !== ref_byte[addr]) begin
        mismatched++;
        $display("FAIL %s readdata addr=%h got %h expected %h", name, addr, READDATA, ref_byte[addr]);
      end
    end

    if (!hit) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_byte[addr] = wdata;
      m_dirty[idx] = 1'b1;
    end

    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    #1;
    compared++;
    if (BUSYWAIT !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idle_busywait got %b expected 0", name, BUSYWAIT);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge CLK);
    #1;
    compared++;
    if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags got %b expected 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
    end
    compared++;
    if (READDATA !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_readdata got %h expected 00", READDATA);
    end
    compared++;
    if (MEM_ADDRESS !== 6'h00) begin
      mismatched++;
      $display("FAIL reset_mem_address got %h expected 00", MEM_ADDRESS);
    end
    compared++;
    if (MEM_WRITEDATA !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mem_writedata got %h expected 0", MEM_WRITEDATA);
    end
    @(negedge CLK);
    RESET = 1'b1;
    model_clear();
  endtask

  task automatic test_spec_sequence();
    do_access(1, 0, 8'h04, 8'h00, "cold_read_04");
    do_access(1, 0, 8'h05, 8'h00, "hit_read_05");
    do_access(0, 1, 8'h06, 8'hAB, "hit_write_06");
    do_access(1, 0, 8'h06, 8'h00, "readback_06");
    do_access(1, 0, 8'h24, 8'h00, "evict_dirty_24");
    do_access(0, 1, 8'h10, 8'h55, "write_miss_10");
    do_access(1, 0, 8'h10, 8'h00, "readback_10");
    do_access(1, 0, 8'h30, 8'h00, "evict_dirty_30");
    do_access(1, 0, 8'h06, 8'h00, "index_wrap_06");
    do_access(1, 0, 8'h00, 8'h00, "index_wrap_00");
    do_access(1, 0, 8'h20, 8'h00, "index_wrap_20");
    do_access(1, 0, 8'h00, 8'h00, "index_wrap_00b");
  endtask

  task automatic test_read_write_both();
    do_access(1, 1, 8'h4B, 8'hC3, "both_write_wins");
    do_access(1, 0, 8'h4B, 8'h00, "both_readback");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] d;
    do_access(1, 0, 8'h5C, 8'h00, "b2b_load");
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      a = 8'h5C | 8'(k);
      d = 8'($urandom);
      READ = 1'b0; WRITE = 1'b1; ADDRESS = a; WRITEDATA = d;
      #1;
      compared++;
      if (BUSYWAIT !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_write_stall addr=%h got %b expected 0", a, BUSYWAIT);
      end
      ref_byte[a] = d;
      m_dirty[3'd7] = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      a = 8'h5C | 8'($urandom_range(0, 3));
      READ = 1'b1; WRITE = 1'b0; ADDRESS = a;
      #1;
      compared++;
      if (BUSYWAIT !== 1'b0 || READDATA !== ref_byte[a]) begin
        mismatched++;
        $display("FAIL b2b_read addr=%h got busy=%b data=%h expected busy=0 data=%h",
                 a, BUSYWAIT, READDATA, ref_byte[a]);
      end
    end
    @(negedge CLK);
    READ = 1'b0;
  endtask

  task automatic test_drop_mid_miss();
    logic [7:0] addr;
    logic [7:0] victim;
    logic [2:0] idx;
    for (int t = 0; t < 3; t++) begin
      idx    = 3'($urandom_range(0, 7));
      addr   = {m_valid[idx] ? m_tag[idx] + 3'd1 : 3'($urandom_range(0, 7)), idx,
                2'($urandom_range(0, 3))};
      victim = {m_tag[idx], idx, 2'b00};
      @(negedge CLK);
      READ = 1'b1; ADDRESS = addr;
      repeat (3) @(negedge CLK);
      READ = 1'b0;
      repeat (25) @(negedge CLK);
      #1;
      compared++;
      if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
        mismatched++;
        $display("FAIL drop_quiesce addr=%h got %b expected 000", addr,
                 {BUSYWAIT, MEM_READ, MEM_WRITE});
      end
      m_valid[idx] = 1'b1; m_tag[idx] = addr[7:5]; m_dirty[idx] = 1'b0;
      do_access(1, 0, addr, 8'h00, "drop_then_hit");
      do_access(1, 0, victim, 8'h00, "drop_victim_reload");
    end
  endtask

  task automatic test_random();
    logic [7:0] addr;
    int op;
    for (int i = 0; i < 80; i++) begin
      addr = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op   = $urandom_range(0, 9);
      if (op < 5)       do_access(1, 0, addr, 8'h00, "rand_read");
      else if (op < 9)  do_access(0, 1, addr, 8'($urandom), "rand_write");
      else              do_access(1, 1, addr, 8'($urandom), "rand_both");
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h04;
    repeat (4) @(negedge CLK);
    #1;
    compared++;
    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h01) begin
      mismatched++;
      $display("FAIL midfetch_active got read=%b addr=%h expected read=1 addr=01", MEM_READ, MEM_ADDRESS);
    end
    #1;
    RESET = 1'b0;
    #1;
    compared++;
    if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
      mismatched++;
      $display("FAIL midfetch_abort got %b expected 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
    end
    compared++;
    if (MEM_ADDRESS !== 6'h00) begin
      mismatched++;
      $display("FAIL midfetch_abort_addr got %h expected 00", MEM_ADDRESS);
    end
    READ = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    model_clear();
    do_access(1, 0, 8'h04, 8'h00, "post_abort_read_04");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    logic [31:0] blk;
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    for (int i = 0; i < 64; i++) seed_blk[i] = $urandom;
    for (int b = 0; b < 256; b++) begin
      blk = seed_blk[b >> 2];
      ref_byte[b] = blk[(b % 4) * 8 +: 8];
    end
    model_clear();

    test_reset();
    test_spec_sequence();
    test_read_write_both();
    test_back_to_back();
    test_drop_mid_miss();
    test_random();
    test_reset_mid_fetch();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
